// File: rtl/ps2_pkg.sv
// Shared frame-state type, protocol constants and default key table for the PS/2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_frame_state_t;

    localparam logic [7:0] PS2_EXTEND = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;

    // Key codes are {ext, code}: ext marks keys sent behind an E0 prefix.
    localparam logic [8:0] PS2_UP    = 9'h175;
    localparam logic [8:0] PS2_DOWN  = 9'h172;
    localparam logic [8:0] PS2_LEFT  = 9'h16B;
    localparam logic [8:0] PS2_RIGHT = 9'h174;
    localparam logic [8:0] PS2_ENTER = 9'h05A;

    function automatic int ps2_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line filter, falling-edge detect and 11-bit frame receiver with idle timeout.
// Odd-parity checking is compiled in when PS2_PARITY_CHK_EN is defined.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [FILT_LEN-1:0] clk_hist_q, clk_hist_d, data_hist_q, data_hist_d;
    logic                clk_lvl_q, clk_lvl_d, data_lvl_q, data_lvl_d;
    logic                clk_dly_q, clk_dly_d, fall_q, fall_d;
    ps2_frame_state_t    state_q, state_d;
    logic [7:0]          shift_q, shift_d, byte_q, byte_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic                parity_ok;

`ifdef PS2_PARITY_CHK_EN
    logic par_q, par_d;
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        clk_hist_d   = {clk_hist_q[FILT_LEN-2:0], ps2_clk};
        data_hist_d  = {data_hist_q[FILT_LEN-2:0], ps2_data};
        clk_lvl_d    = (&clk_hist_q) ? 1'b1 : ((~|clk_hist_q) ? 1'b0 : clk_lvl_q);
        data_lvl_d   = (&data_hist_q) ? 1'b1 : ((~|data_hist_q) ? 1'b0 : data_lvl_q);
        clk_dly_d    = clk_lvl_q;
        fall_d       = clk_dly_q & ~clk_lvl_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = (state_q == IDLE || fall_q) ? '0 : tmo_q + TMO_ONE;
`ifdef PS2_PARITY_CHK_EN
        par_d        = par_q;
`endif
        // A stalled frame is abandoned even if an edge arrives in the same cycle.
        if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!data_lvl_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_lvl_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                    par_d   = data_lvl_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_lvl_q && parity_ok) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_hist_q   <= '1;
            data_hist_q  <= '1;
            clk_lvl_q    <= 1'b1;
            data_lvl_q   <= 1'b1;
            clk_dly_q    <= 1'b1;
            fall_q       <= 1'b0;
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            clk_hist_q   <= clk_hist_d;
            data_hist_q  <= data_hist_d;
            clk_lvl_q    <= clk_lvl_d;
            data_lvl_q   <= data_lvl_d;
            clk_dly_q    <= clk_dly_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHK_EN
            par_q        <= par_d;
`endif
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: make/break/E0 decode against a key table, key level/pulse vectors
// and a show-ahead event FIFO. Parity checking follows PS2_PARITY_CHK_EN in ps2_rx_frame.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS    = 5,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = {PS2_ENTER, PS2_RIGHT, PS2_LEFT, PS2_DOWN, PS2_UP},
    parameter int                    FILT_LEN    = 8,
    parameter int                    TIMEOUT_CYC = 1048575,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    output logic [NUM_KEYS-1:0]               key_state,
    output logic [NUM_KEYS-1:0]               key_press,
    output logic [NUM_KEYS-1:0]               key_release,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [ps2_idx_width(NUM_KEYS):0]  evt_data,
    output logic                              evt_overflow,
    output logic                              frame_err
);

    localparam int            IW      = ps2_idx_width(NUM_KEYS);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic                rx_valid, rx_err;
    logic [7:0]          rx_byte;
    logic                ext_q, ext_d, brk_q, brk_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d, key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic                hit, push, pop, push_ok, full, ovf_q, ovf_d;
    logic [IW-1:0]       hit_idx;
    logic [IW:0]         push_data;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IW:0]         mem_q [FIFO_DEPTH];

    ps2_rx_frame #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (rx_err)
    );

    assign evt_valid = (wr_ptr_q != rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = evt_valid & evt_ready;

    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_state_d   = key_state_q;
        key_press_d   = '0;
        key_release_d = '0;
        push          = 1'b0;
        push_data     = '0;
        hit           = 1'b0;
        hit_idx       = '0;
        // Descending scan so the lowest matching index is the one that sticks.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == {ext_q, rx_byte}) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXTEND) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BREAK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (hit && !brk_q && !key_state_q[hit_idx]) begin
                    key_state_d[hit_idx] = 1'b1;
                    key_press_d[hit_idx] = 1'b1;
                    push                 = 1'b1;
                    push_data            = {1'b1, hit_idx};
                end else if (hit && brk_q && key_state_q[hit_idx]) begin
                    key_state_d[hit_idx]   = 1'b0;
                    key_release_d[hit_idx] = 1'b1;
                    push                   = 1'b1;
                    push_data              = {1'b0, hit_idx};
                end
            end
        end
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_ok  = push & (~full | pop);
        ovf_d    = ovf_q | (push & full & ~pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            ovf_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            ovf_q         <= ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage has no reset; evt_data is gated by evt_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign evt_data     = evt_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign key_state    = key_state_q;
    assign key_press    = key_press_q;
    assign key_release  = key_release_q;
    assign evt_overflow = ovf_q;
    assign frame_err    = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed protocol scenarios plus random byte streams
// compared against a byte-level key/event model. Parity expectations follow PS2_PARITY_CHK_EN.
module tb_ps2_key_decoder;

    localparam int NK      = 5;
    localparam int FILT    = 4;
    localparam int TMO     = 300;
    localparam int DEPTH   = 4;
    localparam int HALF    = 20;
    localparam int GAP     = 10;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, evt_ready;
    logic [4:0] key_state, key_press, key_release;
    logic       evt_valid, evt_overflow, frame_err;
    logic [3:0] evt_data;

    ps2_key_decoder #(
        .NUM_KEYS    (NK),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_state    (key_state),
        .key_press    (key_press),
        .key_release  (key_release),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_overflow (evt_overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Observations gathered by the monitor (written only there).
    int         press_n [NK];
    int         rel_n   [NK];
    int         multi_n = 0;
    int         ferr_n  = 0;
    logic [3:0] got_mem [256];
    int         got_n   = 0;
    logic       cap_en;

    // Reference model state (written only by the stimulus block).
    logic [8:0] codes [NK] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A};
    logic       m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
    logic [4:0] m_held = '0;
    int         exp_press [NK];
    int         exp_rel   [NK];
    int         exp_ferr = 0;
    logic [3:0] exp_mem [256];
    int         exp_n = 0;
    int         chk_ptr = 0;
    logic [3:0] mq [$];

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (key_press[k])   press_n[k]++;
            if (key_release[k]) rel_n[k]++;
        end
        if ($countones(key_press) > 1 || $countones(key_release) > 1) multi_n++;
        if (frame_err) ferr_n++;
        if (cap_en && evt_valid && evt_ready && got_n < 256) begin
            got_mem[got_n] = evt_data;
            got_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [3:0] e);
        if (evt_ready) begin
            exp_mem[exp_n] = e;
            exp_n++;
        end else if (mq.size() < DEPTH) begin
            mq.push_back(e);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        int idx = -1;
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            exp_ferr++;
            return;
        end
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < NK && idx < 0; i++)
                if (codes[i] == {m_ext, b}) idx = i;
            if (idx >= 0 && !m_brk && !m_held[idx]) begin
                m_held[idx] = 1'b1;
                exp_press[idx]++;
                model_push({1'b1, 3'(idx)});
            end else if (idx >= 0 && m_brk && m_held[idx]) begin
                m_held[idx] = 1'b0;
                exp_rel[idx]++;
                model_push({1'b0, 3'(idx)});
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends start + nbits data bits; a full frame (nbits == 8) adds parity and stop.
    task automatic ps2_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        if (nbits == 8) begin
            ps2_bit(~^b ^ bad_par);
            ps2_bit(1'b1);
        end
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        ps2_frame(b, 1'b0, 8);
        model_byte(b, 1'b1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check(tag, key_state, m_held);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        check({tag, "_state"}, key_state, m_held);
        for (int k = 0; k < NK; k++) begin
            check({tag, "_press_cnt"}, press_n[k], exp_press[k]);
            check({tag, "_release_cnt"}, rel_n[k], exp_rel[k]);
        end
        check({tag, "_multi_hot"}, multi_n, 0);
        check({tag, "_frame_err_cnt"}, ferr_n, exp_ferr);
        check({tag, "_evt_cnt"}, got_n, exp_n);
        for (int i = chk_ptr; i < exp_n && i < got_n; i++)
            check({tag, "_evt_data"}, got_mem[i], exp_mem[i]);
        chk_ptr = exp_n;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rst_n     = 1'b0;
        evt_ready = 1'b1;
        cap_en    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_key_state", key_state, 0);
        check("rst_key_press", key_press, 0);
        check("rst_key_release", key_release, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_overflow", evt_overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Extended key press and release.
        send(8'hE0); send(8'h75);
        check("up_press_state", key_state, 5'b00001);
        check_all("up_press");
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_release_state", key_state, 5'b00000);
        check_all("up_release");

        // Typematic repeats produce a single press event.
        for (int r = 0; r < 3; r++) begin
            send(8'h5A);
            @(negedge clk);
            check("typematic_held", key_state[4], 1'b1);
        end
        send(8'hF0); send(8'h5A);
        check_all("typematic");

        // FIFO fills while the consumer stalls; overflow is sticky.
        evt_ready = 1'b0;
        cap_en    = 1'b0;
        foreach (codes[k]) begin
            if (k < 3) begin
                send(8'hE0); send(codes[k][7:0]);
                send(8'hE0); send(8'hF0); send(codes[k][7:0]);
            end
        end
        @(negedge clk);
        check("ovf_flag", evt_overflow, m_ovf);
        check("ovf_flag_set", evt_overflow, 1'b1);
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            check("drain_valid", evt_valid, 1'b1);
            check("drain_data", evt_data, mq[j]);
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        mq.delete();
        @(negedge clk);
        check("drain_empty", evt_valid, 1'b0);
        evt_ready = 1'b1;
        cap_en    = 1'b1;
        check_all("overflow");

        // Corrupted parity on the code byte after an E0 prefix.
        send(8'hE0);
        ps2_frame(8'h75, 1'b1, 8);
`ifdef PS2_PARITY_CHK_EN
        model_byte(8'h75, 1'b0);
`else
        model_byte(8'h75, 1'b1);
`endif
        check_all("parity");
        send(8'hE0); send(8'hF0); send(8'h75);
        check_all("parity_cleanup");

        // Frame abandoned after four data bits, then a clean extended code.
        ps2_frame(8'h72, 1'b0, 4);
        repeat (TMO + 50) @(posedge clk);
        model_byte(8'h00, 1'b0);
        check_all("timeout_err");
        send(8'hE0); send(8'h72);
        check("timeout_down_state", key_state, 5'b00010);
        check_all("timeout_recover");
        send(8'hE0); send(8'hF0); send(8'h72);
        check_all("down_release");

        // Reset mid-frame with events queued.
        evt_ready = 1'b0;
        cap_en    = 1'b0;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        check("pre_rst_valid", evt_valid, mq.size() != 0);
        check("pre_rst_overflow", evt_overflow, 1'b1);
        ps2_frame(8'h5A, 1'b0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_key_state", key_state, 0);
        check("midrst_evt_valid", evt_valid, 0);
        check("midrst_evt_data", evt_data, 0);
        check("midrst_overflow", evt_overflow, 0);
        check("midrst_frame_err", frame_err, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_held = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_ovf  = 1'b0;
        mq.delete();
        evt_ready = 1'b1;
        cap_en    = 1'b1;
        repeat (10) @(posedge clk);
        send(8'hE0); send(8'h74);
        check("post_rst_state", key_state, 5'b01000);
        check_all("post_rst");

        // Random byte stream drawn from prefixes, table codes and unmatched codes.
        begin
            logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B,
                                      8'h74, 8'h5A, 8'hAA, 8'hFA, 8'hE1};
            for (int n = 0; n < 40; n++) begin
                send(pool[$urandom_range(0, 9)]);
                check_state("rand_state");
            end
        end
        check_all("random");
        @(negedge clk);
        check("final_overflow", evt_overflow, m_ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver and key decoder that succeeds the fixed five-key decoder. It filters and frames the PS/2 clock/data lines and decodes make, break and E0-extended scan codes against a parameter-supplied key table. It outputs per-key level and pulse vectors plus a buffered key-event stream with valid/ready handshake. It sits between the board PS/2 pins and the game control logic.

## Interface
- `NUM_KEYS`, 5: number of decoded keys, 1..32.
- `KEY_CODES`, {9'h05A,9'h174,9'h16B,9'h172,9'h175}: packed NUM_KEYS×9 table. Entry i is bits [9i+8:9i], formatted {ext, code}. Default order is up, down, left, right, enter for i = 0..4.
- `FILT_LEN`, 8: glitch-filter length in clk cycles, ≥2.
- `TIMEOUT_CYC`, 1048575: number of idle clk cycles inside a frame before the frame is aborted.
- `FIFO_DEPTH`, 4: event FIFO depth, power of two, ≥2.
- `clk` in 1: system clock. Everything is single clock domain.
- `rst_n` in 1: synchronous reset, active low.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `key_state` out NUM_KEYS: level, 1 while the key is held. Reset value 0.
- `key_press` out NUM_KEYS: one-cycle pulse on a new press. Reset value 0.
- `key_release` out NUM_KEYS: one-cycle pulse on release. Reset value 0.
- `evt_valid` out 1: FIFO non-empty. Reset value 0.
- `evt_ready` in 1: consumer accepts the head event.
- `evt_data` out IW+1: {make, index}, where IW = max(1, $clog2(NUM_KEYS)). Reset value 0.
- `evt_overflow` out 1: sticky flag, set when an event is dropped because the FIFO is full. Cleared only by reset.
- `frame_err` out 1: one-cycle pulse on a bad stop bit, bad parity, or timeout. Reset value 0.

## Operation
- Filter: shift a FILT_LEN-bit history per line. The synced level changes only when all history bits agree. Reset state is all ones, so the synced level is 1.
- Falling edge: detected as synced ps2_clk going 1→0. Detection is registered, giving one pulse per edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP. All transitions happen on a falling-edge pulse.
  - IDLE→DATA when data = 0 (start bit).
  - DATA captures 8 bits LSB first, then moves to PARITY after bit 7.
  - PARITY latches the parity bit.
  - STOP requires data = 1, then returns to IDLE.
- Frame validity: a frame is good if the stop bit is 1 and, with the macro enabled, odd parity over data+parity holds. Any other outcome discards the byte, pulses frame_err, and clears the prefix flags.
- Timeout: the counter runs only outside IDLE and is cleared by each falling edge. When it reaches TIMEOUT_CYC−1, the FSM forces IDLE, pulses frame_err, and clears the prefix flags. Timeout has priority over a coincident edge.
- Byte decode, applied to good bytes only:
  - E0 sets `ext`. F0 sets `brk`.
  - Any other byte is looked up as {ext, code}; the lowest matching index wins. `ext` and `brk` are cleared after the lookup, whether or not a key matched.
  - Make of a key with key_state = 0: set key_state, pulse key_press, push {1, idx}.
  - Make of a key already held (typematic repeat): no change, no event.
  - Break of a held key: clear key_state, pulse key_release, push {0, idx}.
  - Break of a key not held: ignored.
  - Unmatched codes (including AA, FA, E1): no key effect.
- FIFO behaviour:
  - Show-ahead: evt_data is the head entry whenever evt_valid = 1.
  - Pop happens on evt_valid & evt_ready.
  - A push while full is dropped and sets evt_overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A push while empty is visible on the next cycle.
- Reset: asserting rst_n mid-frame or mid-event clears the FSM, prefix flags, counters, FIFO, and all outputs within the same clock edge.

## Timing
- T is the cycle in which the stop-bit falling-edge pulse is high.
- Byte valid is internal at T+1.
- key_state, key_press, key_release and the FIFO write all occur at T+2.
- evt_valid rises at T+2 if the FIFO was empty.
- Pin-to-edge-detect latency is FILT_LEN+2 cycles.
- frame_err pulses at T+1 for stop/parity errors, or in the cycle after the timeout is reached.
- At most one event is generated per byte. Pulse vectors are one-hot or zero.

## Configuration
- `PS2_PARITY_CHK_EN` defined: odd-parity failures discard the frame and pulse frame_err.
- Not defined: the parity bit is sampled and ignored, and only the stop bit is checked.

## Structure
- Package `ps2_pkg` holds:
  - Frame state enum `ps2_frame_state_t` (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_EXTEND` = 8'hE0 and `PS2_BREAK` = 8'hF0.
  - Default key codes `PS2_UP`, `PS2_DOWN`, `PS2_LEFT`, `PS2_RIGHT`, `PS2_ENTER` in 9-bit {ext, code} form.
- Sub-module `ps2_rx_frame` contains the filter, edge detect, frame FSM, timeout and parity check. It outputs a byte_valid/byte pulse and frame_err.
- The top level contains the decode, key state and event FIFO.

## Test plan
- Send E0 75, then E0 F0 75, with defaults and evt_ready = 1. Expected: key_state[0] rises, key_press = 5'b00001 pulse, event {1,0}; then release, key_release pulse, event {0,0}.
- Send 5A three times (typematic), then F0 5A. Expected: exactly one press event {1,4} and one release {0,4}; key_state[4] is high throughout the repeats.
- Hold evt_ready = 0, then press and release up, down and left (6 events, FIFO_DEPTH = 4). Expected: 4 events queued, evt_overflow = 1, first 4 drained in order {1,0},{0,0},{1,1},{0,1}.
- Send 75 with a corrupted parity bit and PS2_PARITY_CHK_EN defined. Expected: frame_err pulse, no state change. With the macro undefined, the same frame is accepted.
- Stop after 4 data bits, wait TIMEOUT_CYC cycles (use a small parameter value), then send a clean E0 72. Expected: frame_err pulse, then key_state[1] = 1.
- Assert rst_n low for one cycle mid-frame with 2 events queued. Expected: all outputs 0 and evt_valid = 0 the next cycle; the next full frame decodes correctly.
